// File: rtl/hd_timing_gen.sv
// HD raster timing generator: pixel strobe/clock, syncs, DE and position; outputs registered, 1 clk behind the counters, no backpressure.
// Define HD_TIMING_GENLOCK_EN to let i_frame_end re-phase the vertical raster onto LOCK_LINE.
module hd_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOCK_LINE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_end,
  output logic        o_hd_clk,
  output logic        o_pix_en,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_h_pos,
  output logic [10:0] o_v_pos,
  output logic        o_frame_start,
  output logic        o_locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic [11:0]   H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0]   H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0]   H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]   H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0]   V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0]   V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [11:0]   h;
  logic [10:0]   v;
  logic [10:0]   v_inc;
  logic [10:0]   v_next;
  logic          pix_tick;
  logic          line_wrap;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          locked_q;

  assign pix_tick  = (div == DIV_LAST);
  assign line_wrap = pix_tick && (h == H_LAST);
  assign h_in_sync = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
  assign v_in_sync = (v >= V_SYNC_BEG) && (v < V_SYNC_END);

  always_comb begin
    v_inc = v + 11'd1;
    if (v == V_LAST) begin
      v_inc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (line_wrap) begin
      h <= '0;
      v <= v_next;
    end else if (pix_tick) begin
      h <= h + 12'd1;
    end
  end

`ifdef HD_TIMING_GENLOCK_EN
  localparam logic [10:0] LOCK_V    = 11'(LOCK_LINE);
  localparam logic [10:0] LOCK_PREV = (LOCK_LINE == 0) ? V_LAST : 11'(LOCK_LINE - 1);

  logic lock_pend;
  logic lock_load;

  // A frame_end coinciding with the wrap is honoured immediately rather than a line late.
  assign lock_load = line_wrap && (lock_pend || i_frame_end);
  assign v_next    = lock_load ? LOCK_V : v_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_pend <= 1'b0;
    end else if (lock_load) begin
      lock_pend <= 1'b0;
    end else if (i_frame_end) begin
      lock_pend <= 1'b1;
    end
  end

  // Locked only when the load landed where the free-running raster was going anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else if (lock_load) begin
      locked_q <= (v == LOCK_PREV);
    end
  end
`else
  logic        unused_frame_end;
  logic [31:0] unused_lock_line;

  assign unused_frame_end = i_frame_end;
  assign unused_lock_line = 32'(LOCK_LINE);
  assign v_next           = v_inc;
  assign locked_q         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_hd_clk      <= 1'b0;
      o_pix_en      <= 1'b0;
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_de          <= 1'b0;
      o_h_pos       <= '0;
      o_v_pos       <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hd_clk      <= (div < DIV_HALF);
      o_pix_en      <= pix_tick;
      o_hsync       <= h_in_sync ? HS_POL : ~HS_POL;
      o_vsync       <= v_in_sync ? VS_POL : ~VS_POL;
      o_de          <= (h < H_ACT_END) && (v < V_ACT_END);
      o_h_pos       <= h;
      o_v_pos       <= v;
      o_frame_start <= line_wrap && (v_next == '0);
    end
  end

  assign o_locked = locked_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Bench for hd_timing_gen on a 24x7 pixel raster at 4 clks/pixel; expectations derived from elapsed time.
module tb_hd_timing_gen;

  localparam int CLK_DIV = 4;
  localparam int H_A = 16, H_F = 2, H_S = 3, H_B = 3;
  localparam int V_A = 4,  V_F = 1, V_S = 1, V_B = 1;
  localparam int H_TOT = H_A + H_F + H_S + H_B;
  localparam int V_TOT = V_A + V_F + V_S + V_B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_frame_end = 1'b0;
  logic        o_hd_clk, o_pix_en, o_hsync, o_vsync, o_de, o_frame_start, o_locked;
  logic [11:0] o_h_pos;
  logic [10:0] o_v_pos;

  int total = 0;
  int fails = 0;
  int n = 0;

  hd_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_LINE(0)
  ) dut (
    .clk(clk), .rst(rst), .i_frame_end(i_frame_end),
    .o_hd_clk(o_hd_clk), .o_pix_en(o_pix_en), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_de(o_de), .o_h_pos(o_h_pos), .o_v_pos(o_v_pos),
    .o_frame_start(o_frame_start), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_hd_clk", 32'(o_hd_clk), 32'd0);
    chk("rst_pix_en", 32'(o_pix_en), 32'd0);
    chk("rst_hsync", 32'(o_hsync), 32'd0);
    chk("rst_vsync", 32'(o_vsync), 32'd0);
    chk("rst_de", 32'(o_de), 32'd0);
    chk("rst_h_pos", 32'(o_h_pos), 32'd0);
    chk("rst_v_pos", 32'(o_v_pos), 32'd0);
    chk("rst_frame_start", 32'(o_frame_start), 32'd0);
    chk("rst_locked", 32'(o_locked), 32'd0);
  endtask

  // t = system clocks of raster time elapsed since (0,0); outputs show that instant.
  task automatic check_model(input int t, input bit fs_force, input bit lk);
    int d, p, h, v;
    bit pe;
    d  = t % CLK_DIV;
    p  = t / CLK_DIV;
    h  = p % H_TOT;
    v  = (p / H_TOT) % V_TOT;
    pe = (d == CLK_DIV - 1);
    chk("hd_clk", 32'(o_hd_clk), 32'(d < CLK_DIV / 2));
    chk("pix_en", 32'(o_pix_en), 32'(pe));
    chk("h_pos", 32'(o_h_pos), 32'(h));
    chk("v_pos", 32'(o_v_pos), 32'(v));
    chk("de", 32'(o_de), 32'(h < H_A && v < V_A));
    chk("hsync", 32'(o_hsync), 32'(h >= H_A + H_F && h < H_A + H_F + H_S));
    chk("vsync", 32'(o_vsync), 32'(v >= V_A + V_F && v < V_A + V_F + V_S));
    chk("frame_start", 32'(o_frame_start),
        32'(pe && h == H_TOT - 1 && (v == V_TOT - 1 || fs_force)));
    chk("locked", 32'(o_locked), 32'(lk));
  endtask

  task automatic do_reset(input int edges);
    rst = 1'b1;
    i_frame_end = 1'b0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk); #1;
      check_reset();
    end
    rst = 1'b0;
    n = 0;
  endtask

  task automatic run_free(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      n++;
      check_model(n - 1, 1'b0, 1'b0);
`ifndef HD_TIMING_GENLOCK_EN
      // Without genlock these pulses must have no effect on the raster.
      i_frame_end = ($urandom_range(0, 19) == 0);
`endif
    end
  endtask

  initial begin
    do_reset(3);
    // Two full frames plus a little: pixel strobe, syncs, DE and frame_start.
    run_free(2 * 672 + 10);

    // Reset at h=10, v=2, then a clean restart.
    do_reset(1);
    run_free((2 * H_TOT + 10) * CLK_DIV);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset();
    rst = 1'b0;
    n = 0;
    run_free(700);

    for (int k = 0; k < 3; k++) begin
      run_free($urandom_range(1, 700));
      do_reset($urandom_range(1, 3));
      run_free(100);
    end

`ifdef HD_TIMING_GENLOCK_EN
    // Pulse at v=3: correcting jump to line 0 at the end of line 3 (skip 3 lines).
    // Aligned pulses every 672 clks then lock; a doubled pulse and one on the wrap clk keep it.
    do_reset(2);
    for (int i = 0; i < 2500; i++) begin
      int t;
      @(posedge clk); #1;
      n++;
      t = n - 1;
      check_model((t > 383) ? t + 3 * H_TOT * CLK_DIV : t, (t == 383), (t >= 1055));
      i_frame_end = (n == 308 || n == 980 || n == 1652 || n == 1660 || n == 2399);
    end
    i_frame_end = 1'b0;
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
